pulse_cmd_master: RTL and testbench

PULSE_CMD_MASTER -- requirements
Module: pulse_cmd_master

---
 rtl/pulse_cmd_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_pulse_cmd_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_master.sv
// ---------------------------------------------------------------------------
// pulse_cmd_master
//
// Sends one 5-byte command frame to a UART transmitter, then waits for a
// single-byte echo. The echo is compared against an 8-bit checksum of the
// data word. The frame is data[7:0], data[15:8], data[23:16], data[31:24],
// then ctrl.
//
// Ports
//   clk              in   1   single clock, rising edge
//   rst_n            in   1   asynchronous active-low reset
//   cmd_valid        in   1   command request
//   cmd_ready        out  1   high only while idle
//   cmd_ctrl         in   8   control byte (sent last, not in checksum)
//   cmd_data         in  32   parameter value
//   transmit         out  1   one-cycle strobe to the UART transmitter
//   tx_byte          out  8   byte to send, valid with transmit
//   is_transmitting  in   1   UART transmitter busy
//   received         in   1   one-cycle strobe, rx_byte valid
//   rx_byte          in   8   received byte
//   recv_error       in   1   one-cycle framing error strobe
//   resp_valid       out  1   one-cycle transaction-complete strobe
//   resp_ok          out  1   echo matched checksum
//   resp_timeout     out  1   no echo within TIMEOUT_CYCLES
//   resp_byte        out  8   echo byte (0 on timeout), held between responses
// ---------------------------------------------------------------------------
module pulse_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_ctrl,
  input  logic [31:0] cmd_data,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic        resp_valid,
  output logic        resp_ok,
  output logic        resp_timeout,
  output logic [7:0]  resp_byte
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_HI   = 3'd2,
    WAIT_LO   = 3'd3,
    WAIT_ECHO = 3'd4,
    RESP      = 3'd5
  } state_t;

  // Counter value on which the echo wait gives up.
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  // Mod-256 sum of the four data bytes; the control byte is not included.
  function automatic logic [7:0] checksum8(input logic [31:0] d);
    logic [7:0] s;
    s = d[7:0] + d[15:8];
    s = s + d[23:16];
    s = s + d[31:24];
    return s;
  endfunction

  // Frame byte for a given index: data bytes LSB first, then ctrl.
  function automatic logic [7:0] frame_byte(input logic [31:0] d,
                                            input logic [7:0]  c,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = d[7:0];
      3'd1:    b = d[15:8];
      3'd2:    b = d[23:16];
      3'd3:    b = d[31:24];
      3'd4:    b = c;
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  expected_q, expected_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        transmit_q, transmit_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_ok_q, resp_ok_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic [7:0]  resp_byte_q, resp_byte_d;
  logic        cmd_ready_q, cmd_ready_d;

  // Next-state and next-output logic for the command/echo sequencer.
  always_comb begin
    state_d        = state_q;
    ctrl_d         = ctrl_q;
    data_d         = data_q;
    expected_d     = expected_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    transmit_d     = 1'b0;
    tx_byte_d      = tx_byte_q;
    resp_valid_d   = 1'b0;
    resp_ok_d      = resp_ok_q;
    resp_timeout_d = resp_timeout_q;
    resp_byte_d    = resp_byte_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ctrl_d     = cmd_ctrl;
          data_d     = cmd_data;
          expected_d = checksum8(cmd_data);
          idx_d      = 3'd0;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (!is_transmitting) begin
          tx_byte_d  = frame_byte(data_q, ctrl_q, idx_q);
          transmit_d = 1'b1;
          state_d    = WAIT_HI;
        end else begin
          state_d = LOAD;
        end
      end

      // The transmitter must be seen busy before its idle level means
      // "byte finished"; otherwise a slow busy flag would skip a byte.
      WAIT_HI: begin
        if (is_transmitting) begin
          state_d = WAIT_LO;
        end else begin
          state_d = WAIT_HI;
        end
      end

      WAIT_LO: begin
        if (!is_transmitting) begin
          if (idx_q < 3'd4) begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end else begin
            cnt_d   = 32'd0;
            state_d = WAIT_ECHO;
          end
        end else begin
          state_d = WAIT_LO;
        end
      end

      // A received byte beats both a framing error and the timeout.
      WAIT_ECHO: begin
        cnt_d = cnt_q + 32'd1;
        if (received) begin
          resp_byte_d    = rx_byte;
          resp_ok_d      = (rx_byte == expected_q);
          resp_timeout_d = 1'b0;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else if (recv_error) begin
          resp_ok_d      = 1'b0;
          resp_timeout_d = 1'b0;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_byte_d    = 8'd0;
          resp_ok_d      = 1'b0;
          resp_timeout_d = 1'b1;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else begin
          state_d = WAIT_ECHO;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered so it tracks the state actually being entered.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ctrl_q         <= 8'd0;
      data_q         <= 32'd0;
      expected_q     <= 8'd0;
      idx_q          <= 3'd0;
      cnt_q          <= 32'd0;
      transmit_q     <= 1'b0;
      tx_byte_q      <= 8'd0;
      resp_valid_q   <= 1'b0;
      resp_ok_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_byte_q    <= 8'd0;
      cmd_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      ctrl_q         <= ctrl_d;
      data_q         <= data_d;
      expected_q     <= expected_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      transmit_q     <= transmit_d;
      tx_byte_q      <= tx_byte_d;
      resp_valid_q   <= resp_valid_d;
      resp_ok_q      <= resp_ok_d;
      resp_timeout_q <= resp_timeout_d;
      resp_byte_q    <= resp_byte_d;
      cmd_ready_q    <= cmd_ready_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign transmit     = transmit_q;
  assign tx_byte      = tx_byte_q;
  assign resp_valid   = resp_valid_q;
  assign resp_ok      = resp_ok_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_byte    = resp_byte_q;

endmodule

// File: tb/tb_pulse_cmd_master.sv
// ---------------------------------------------------------------------------
// Testbench for pulse_cmd_master. The bench plays the UART: it watches the
// transmit strobes, toggles is_transmitting, and returns echo bytes, framing
// errors or silence. Expected frames and responses come from a small model
// of the transaction rules (byte order, checksum, echo timing).
// ---------------------------------------------------------------------------
module tb_pulse_cmd_master;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_ctrl;
  logic [31:0] cmd_data;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        resp_valid;
  logic        resp_ok;
  logic        resp_timeout;
  logic [7:0]  resp_byte;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor counters, sampled on the rising edge.
  int   tx_cnt  = 0;
  int   rv_cnt  = 0;
  int   consec  = 0;
  logic prev_tx = 1'b0;

  // Resp_byte the model believes the DUT is holding.
  logic [7:0] last_byte = 8'd0;

  pulse_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_ctrl        (cmd_ctrl),
    .cmd_data        (cmd_data),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .resp_valid      (resp_valid),
    .resp_ok         (resp_ok),
    .resp_timeout    (resp_timeout),
    .resp_byte       (resp_byte)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count strobes and back-to-back transmits.
  always @(posedge clk) begin
    prev_tx <= transmit;
    if (transmit) tx_cnt <= tx_cnt + 1;
    if (transmit && prev_tx) consec <= consec + 1;
    if (resp_valid) rv_cnt <= rv_cnt + 1;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One transaction.
  // mode: 0 correct echo, 1 given echo byte, 2 framing error only,
  //       3 silence (timeout), 4 echo and framing error together.
  // j: cycles after entering the echo wait at which rx strobes arrive.
  // rst_at: byte index at which reset is applied (>4 for none).
  task automatic run_txn(input logic [7:0] c, input logic [31:0] d, input int mode,
                         input logic [7:0] echo_in, input int j, input bit stray,
                         input bit hold, input int rst_at);
    logic [7:0]  exp_tx [5];
    int unsigned s;
    logic [7:0]  sum;
    logic [7:0]  echo;
    logic [7:0]  eb;
    logic        eok;
    logic        eto;
    int          elat;
    bit          drive_rx;
    bit          drive_err;
    int          t;
    int          tx0;
    int          rv0;

    // Model: frame bytes LSB first then ctrl, checksum of data bytes only.
    s = 0;
    for (int k = 0; k < 4; k++) begin
      exp_tx[k] = 8'((d / (32'd1 << (8 * k))) % 32'd256);
      s = s + exp_tx[k];
    end
    exp_tx[4] = c;
    sum = 8'(s % 256);

    echo      = (mode == 0) ? sum : echo_in;
    drive_rx  = (mode == 0) || (mode == 1) || (mode == 4);
    drive_err = (mode == 2) || (mode == 4);
    if (drive_rx) begin
      eb = echo; eok = (echo == sum); eto = 1'b0; elat = j;
    end else if (mode == 2) begin
      eb = last_byte; eok = 1'b0; eto = 1'b0; elat = j;
    end else begin
      eb = 8'd0; eok = 1'b0; eto = 1'b1; elat = TMO;
    end

    tx0 = tx_cnt;
    rv0 = rv_cnt;

    cmd_ctrl  = c;
    cmd_data  = d;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 400) begin step(); t++; end
    check_eq("ready_before_accept", cmd_ready, 1'b1);
    step();
    check_eq("ready_low_after_accept", cmd_ready, 1'b0);
    if (!hold) cmd_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (!transmit && t < 50) begin step(); t++; end
      check_eq($sformatf("tx_seen_%0d", i), transmit, 1'b1);
      if (!transmit) begin
        cmd_valid = 1'b0;
        is_transmitting = 1'b0;
        return;
      end
      check_eq($sformatf("tx_byte_%0d", i), tx_byte, exp_tx[i]);

      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_transmit", transmit, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_tx_byte", tx_byte, 8'd0);
        check_eq("rst_resp_byte", resp_byte, 8'd0);
        cmd_valid = 1'b0;
        is_transmitting = 1'b0;
        last_byte = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check_eq("rst_no_resp", rv_cnt - rv0, 0);
        check_eq("rst_idle_ready", cmd_ready, 1'b1);
        return;
      end

      step();
      check_eq("tx_one_cycle", transmit, 1'b0);
      repeat ($urandom_range(0, 2)) step();
      is_transmitting = 1'b1;
      repeat ($urandom_range(1, 4)) step();
      is_transmitting = 1'b0;

      // Next byte: DUT sits in LOAD one edge later. Keep it busy and throw
      // rx strobes at it; neither the busy flag nor the strobes may leak.
      if (i < 4 && stray) begin
        step();
        received        = 1'b1;
        recv_error      = 1'b1;
        rx_byte         = 8'($urandom);
        is_transmitting = 1'b1;
        step();
        received   = 1'b0;
        recv_error = 1'b0;
        check_eq("load_waits_busy_a", transmit, 1'b0);
        step();
        check_eq("load_waits_busy_b", transmit, 1'b0);
        is_transmitting = 1'b0;
      end
    end

    // Echo wait: t counts cycles since the DUT entered the echo wait.
    step();
    t = 0;
    while (!resp_valid && t < TMO + 20) begin
      if (t == j - 1) begin
        if (drive_rx) begin
          received = 1'b1;
          rx_byte  = echo;
        end
        if (drive_err) begin
          recv_error = 1'b1;
          if (!drive_rx) rx_byte = 8'($urandom);
        end
      end
      step();
      received   = 1'b0;
      recv_error = 1'b0;
      t++;
    end
    check_eq("resp_valid_seen", resp_valid, 1'b1);
    check_eq("resp_latency", t, elat);
    check_eq("resp_ok", resp_ok, eok);
    check_eq("resp_timeout", resp_timeout, eto);
    check_eq("resp_byte", resp_byte, eb);
    check_eq("ready_low_in_resp", cmd_ready, 1'b0);
    last_byte = eb;

    step();
    check_eq("resp_one_cycle", resp_valid, 1'b0);
    check_eq("ready_back_in_idle", cmd_ready, 1'b1);
    check_eq("resp_byte_held", resp_byte, eb);
    check_eq("resp_count", rv_cnt - rv0, 1);
    check_eq("tx_count", tx_cnt - tx0, 5);
  endtask

  initial begin
    int mode;
    int j;
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    cmd_ctrl        = 8'd0;
    cmd_data        = 32'd0;
    is_transmitting = 1'b0;
    received        = 1'b0;
    rx_byte         = 8'd0;
    recv_error      = 1'b0;

    step();
    step();
    check_eq("reset_cmd_ready", cmd_ready, 1'b1);
    check_eq("reset_transmit", transmit, 1'b0);
    check_eq("reset_tx_byte", tx_byte, 8'd0);
    check_eq("reset_resp_valid", resp_valid, 1'b0);
    check_eq("reset_resp_ok", resp_ok, 1'b0);
    check_eq("reset_resp_timeout", resp_timeout, 1'b0);
    check_eq("reset_resp_byte", resp_byte, 8'd0);
    rst_n = 1'b1;
    step();

    // Directed transactions.
    run_txn(8'h00, 32'h000000C8, 1, 8'hC8, 3, 1'b0, 1'b0, 7);
    run_txn(8'h05, 32'h80808080, 1, 8'h00, 5, 1'b0, 1'b0, 7);
    run_txn(8'h02, 32'h01020304, 1, 8'h0B, 2, 1'b0, 1'b0, 7);
    run_txn(8'h07, 32'hDEADBEEF, 2, 8'h00, 4, 1'b1, 1'b0, 7);   // error keeps 0x0B
    run_txn(8'h03, 32'h12345678, 3, 8'h00, 0, 1'b0, 1'b0, 7);   // timeout
    run_txn(8'h08, 32'hCAFEF00D, 1, 8'h5A, TMO, 1'b0, 1'b0, 7); // echo on last cycle
    run_txn(8'h04, 32'h00FF00FF, 4, 8'hFE, 1, 1'b0, 1'b0, 7);   // echo beats error

    // Randomized transactions.
    for (int n = 0; n < 20; n++) begin
      mode = $urandom_range(0, 4);
      j    = (mode == 2) ? $urandom_range(1, TMO - 1) : $urandom_range(1, TMO);
      run_txn(8'($urandom), 32'($urandom), mode, 8'($urandom), j,
              1'($urandom_range(0, 1)), 1'b0, 7);
    end

    // Reset while byte 2 is going out, then a full clean transaction.
    run_txn(8'h01, 32'hA1B2C3D4, 0, 8'h00, 3, 1'b0, 1'b0, 2);
    run_txn(8'h01, 32'h11223344, 0, 8'h00, 6, 1'b0, 1'b0, 7);

    // cmd_valid held high throughout, with stray rx pulses in LOAD.
    run_txn(8'h02, 32'h0badf00d, 0, 8'h00, 7, 1'b1, 1'b1, 7);
    run_txn(8'h03, 32'h76543210, 1, 8'h33, 9, 1'b0, 1'b0, 7);

    check_eq("no_back_to_back_transmit", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
